// File: rtl/ecc7_arbiter.sv
// Two-channel round-robin front end for a shared, 3-stage Hamming(7,4)
// syndrome/correction pipeline with per-channel saturating error counters.
module ecc7_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [6:0] req0_code,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_code,
    output logic       req1_ready,
    input  logic       clear_counts,
    output logic       out0_valid,
    output logic [3:0] out0_data,
    output logic       out0_err,
    output logic [2:0] out0_loc,
    output logic       out1_valid,
    output logic [3:0] out1_data,
    output logic       out1_err,
    output logic [2:0] out1_loc,
    output logic [7:0] err_count0,
    output logic [7:0] err_count1
);

    // Handshake: a codeword transfers in any cycle where reqN_valid && reqN_ready;
    // ready is combinational from both valids and the round-robin pointer.
    logic       grant0, grant1;
    logic       last_q, last_d;

    logic       s1_valid_q, s1_valid_d;
    logic       s1_tag_q, s1_tag_d;
    logic [6:0] s1_code_q, s1_code_d;

    logic       s2_valid_q;
    logic       s2_tag_q;
    logic [6:0] s2_code_q;
    logic [2:0] s2_syn_q, s2_syn_d;

    logic [6:0] fix_code;
    logic [3:0] fix_data;
    logic       fix_err;
    logic [2:0] fix_loc;

    logic       out0_valid_q, out0_valid_d;
    logic [3:0] out0_data_q, out0_data_d;
    logic       out0_err_q, out0_err_d;
    logic [2:0] out0_loc_q, out0_loc_d;
    logic       out1_valid_q, out1_valid_d;
    logic [3:0] out1_data_q, out1_data_d;
    logic       out1_err_q, out1_err_d;
    logic [2:0] out1_loc_q, out1_loc_d;
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    // When both request, the channel that was not served last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        s1_valid_d = grant0 | grant1;
        s1_tag_d   = grant1;
        s1_code_d  = grant1 ? req1_code : req0_code;
        s2_syn_d   = {s1_code_q[3] ^ s1_code_q[4] ^ s1_code_q[5] ^ s1_code_q[6],
                      s1_code_q[1] ^ s1_code_q[2] ^ s1_code_q[5] ^ s1_code_q[6],
                      s1_code_q[0] ^ s1_code_q[2] ^ s1_code_q[4] ^ s1_code_q[6]};
    end

    // A nonzero syndrome names the flipped bit as (syndrome - 1).
    always_comb begin
        fix_code = s2_code_q;
        fix_err  = 1'b0;
        fix_loc  = 3'd0;
        if (s2_syn_q != 3'd0) begin
            fix_loc  = s2_syn_q - 3'd1;
            fix_err  = 1'b1;
            fix_code = s2_code_q ^ (7'd1 << fix_loc);
        end
        fix_data = {fix_code[6], fix_code[5], fix_code[4], fix_code[2]};
    end

    always_comb begin
        out0_valid_d = s2_valid_q & ~s2_tag_q;
        out1_valid_d = s2_valid_q & s2_tag_q;
        out0_data_d  = out0_data_q;
        out0_err_d   = out0_err_q;
        out0_loc_d   = out0_loc_q;
        out1_data_d  = out1_data_q;
        out1_err_d   = out1_err_q;
        out1_loc_d   = out1_loc_q;
        if (out0_valid_d) begin
            out0_data_d = fix_data;
            out0_err_d  = fix_err;
            out0_loc_d  = fix_loc;
        end
        if (out1_valid_d) begin
            out1_data_d = fix_data;
            out1_err_d  = fix_err;
            out1_loc_d  = fix_loc;
        end
    end

    // Counters follow the registered result pulse; clear beats increment.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clear_counts) begin
            cnt0_d = 8'd0;
            cnt1_d = 8'd0;
        end else begin
            if (out0_valid_q && out0_err_q && (cnt0_q != 8'hFF)) begin
                cnt0_d = cnt0_q + 8'd1;
            end
            if (out1_valid_q && out1_err_q && (cnt1_q != 8'hFF)) begin
                cnt1_d = cnt1_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= 1'b0;
            s1_code_q    <= 7'd0;
            s2_valid_q   <= 1'b0;
            s2_tag_q     <= 1'b0;
            s2_code_q    <= 7'd0;
            s2_syn_q     <= 3'd0;
            out0_valid_q <= 1'b0;
            out0_data_q  <= 4'd0;
            out0_err_q   <= 1'b0;
            out0_loc_q   <= 3'd0;
            out1_valid_q <= 1'b0;
            out1_data_q  <= 4'd0;
            out1_err_q   <= 1'b0;
            out1_loc_q   <= 3'd0;
            cnt0_q       <= 8'd0;
            cnt1_q       <= 8'd0;
        end else begin
            last_q       <= last_d;
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            s1_code_q    <= s1_code_d;
            s2_valid_q   <= s1_valid_q;
            s2_tag_q     <= s1_tag_q;
            s2_code_q    <= s1_code_q;
            s2_syn_q     <= s2_syn_d;
            out0_valid_q <= out0_valid_d;
            out0_data_q  <= out0_data_d;
            out0_err_q   <= out0_err_d;
            out0_loc_q   <= out0_loc_d;
            out1_valid_q <= out1_valid_d;
            out1_data_q  <= out1_data_d;
            out1_err_q   <= out1_err_d;
            out1_loc_q   <= out1_loc_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out0_valid = out0_valid_q;
    assign out0_data  = out0_data_q;
    assign out0_err   = out0_err_q;
    assign out0_loc   = out0_loc_q;
    assign out1_valid = out1_valid_q;
    assign out1_data  = out1_data_q;
    assign out1_err   = out1_err_q;
    assign out1_loc   = out1_loc_q;
    assign err_count0 = cnt0_q;
    assign err_count1 = cnt1_q;

endmodule

// File: tb/tb_ecc7_arbiter.sv
// Directed bench for ecc7_arbiter: clean/corrected words, contention,
// counter saturation and clear, and reset while words are in flight.
module tb_ecc7_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [6:0] req0_code;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_code;
    logic       req1_ready;
    logic       clear_counts;
    logic       out0_valid;
    logic [3:0] out0_data;
    logic       out0_err;
    logic [2:0] out0_loc;
    logic       out1_valid;
    logic [3:0] out1_data;
    logic       out1_err;
    logic [2:0] out1_loc;
    logic [7:0] err_count0;
    logic [7:0] err_count1;

    int total;
    int bad;

    ecc7_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_code    (req0_code),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_code    (req1_code),
        .req1_ready   (req1_ready),
        .clear_counts (clear_counts),
        .out0_valid   (out0_valid),
        .out0_data    (out0_data),
        .out0_err     (out0_err),
        .out0_loc     (out0_loc),
        .out1_valid   (out1_valid),
        .out1_data    (out1_data),
        .out1_err     (out1_err),
        .out1_loc     (out1_loc),
        .err_count0   (err_count0),
        .err_count1   (err_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move into the next cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        req0_valid   = 1'b0;
        req0_code    = 7'd0;
        req1_valid   = 1'b0;
        req1_code    = 7'd0;
        clear_counts = 1'b0;
        tick();
        tick();
        chk("rst_out0_valid", 8'(out0_valid), 8'd0);
        chk("rst_out1_valid", 8'(out1_valid), 8'd0);
        chk("rst_cnt0", err_count0, 8'd0);
        chk("rst_ready0_idle", 8'(req0_ready), 8'd0);

        // Clean word 7'h55 on channel 0
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_code  = 7'h55;
        #1;
        chk("clean_ready0", 8'(req0_ready), 8'd1);
        chk("clean_ready1", 8'(req1_ready), 8'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("clean_no_early", 8'(out0_valid), 8'd0);
        tick();
        chk("clean_valid", 8'(out0_valid), 8'd1);
        chk("clean_data", 8'(out0_data), 8'hB);
        chk("clean_err", 8'(out0_err), 8'd0);
        chk("clean_loc", 8'(out0_loc), 8'd0);
        chk("clean_out1_quiet", 8'(out1_valid), 8'd0);
        tick();
        chk("clean_pulse_end", 8'(out0_valid), 8'd0);
        chk("clean_cnt0", err_count0, 8'd0);

        // Bit 4 flipped (7'h45) on channel 1
        req1_valid = 1'b1;
        req1_code  = 7'h45;
        #1;
        chk("err_ready1", 8'(req1_ready), 8'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        chk("err_valid1", 8'(out1_valid), 8'd1);
        chk("err_data1", 8'(out1_data), 8'hB);
        chk("err_err1", 8'(out1_err), 8'd1);
        chk("err_loc1", 8'(out1_loc), 8'd4);
        chk("err_out0_hold_valid", 8'(out0_valid), 8'd0);
        chk("err_out0_hold_data", 8'(out0_data), 8'hB);
        tick();
        chk("err_cnt1", err_count1, 8'd1);
        chk("err_pulse_end1", 8'(out1_valid), 8'd0);

        // Back-to-back: ch0 7'h7F clean, ch1 7'h40 (bit 6), ch0 7'h7B (bit 2)
        req0_valid = 1'b1;
        req0_code  = 7'h7F;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_code  = 7'h40;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_code  = 7'h7B;
        tick();
        req0_valid = 1'b0;
        chk("b2b_valid0_a", 8'(out0_valid), 8'd1);
        chk("b2b_data0_a", 8'(out0_data), 8'hF);
        chk("b2b_err0_a", 8'(out0_err), 8'd0);
        tick();
        chk("b2b_valid1", 8'(out1_valid), 8'd1);
        chk("b2b_data1", 8'(out1_data), 8'h0);
        chk("b2b_loc1", 8'(out1_loc), 8'd6);
        chk("b2b_out0_hold", 8'(out0_data), 8'hF);
        tick();
        chk("b2b_valid0_b", 8'(out0_valid), 8'd1);
        chk("b2b_data0_b", 8'(out0_data), 8'hF);
        chk("b2b_err0_b", 8'(out0_err), 8'd1);
        chk("b2b_loc0_b", 8'(out0_loc), 8'd2);
        chk("b2b_cnt1", err_count1, 8'd2);
        tick();
        chk("b2b_cnt0", err_count0, 8'd1);

        // Contention after reset: grants alternate starting with channel 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_cnt1", err_count1, 8'd0);
        chk("rst2_data0", 8'(out0_data), 8'd0);
        for (int i = 0; i < 10; i++) begin
            req0_valid = (i < 6);
            req0_code  = 7'h01;
            req1_valid = (i < 6);
            req1_code  = 7'h00;
            #1;
            chk($sformatf("cont_ready0_c%0d", i), 8'(req0_ready), 8'((i < 6) && (i % 2 == 0)));
            chk($sformatf("cont_ready1_c%0d", i), 8'(req1_ready), 8'((i < 6) && (i % 2 == 1)));
            chk($sformatf("cont_v0_c%0d", i), 8'(out0_valid), 8'(i == 3 || i == 5 || i == 7));
            chk($sformatf("cont_v1_c%0d", i), 8'(out1_valid), 8'(i == 4 || i == 6 || i == 8));
            if (i == 3 || i == 5 || i == 7) begin
                chk($sformatf("cont_data0_c%0d", i), 8'(out0_data), 8'd0);
                chk($sformatf("cont_err0_c%0d", i), 8'(out0_err), 8'd1);
                chk($sformatf("cont_loc0_c%0d", i), 8'(out0_loc), 8'd0);
            end
            if (i == 4 || i == 6 || i == 8) begin
                chk($sformatf("cont_err1_c%0d", i), 8'(out1_err), 8'd0);
            end
            tick();
        end
        chk("cont_cnt0", err_count0, 8'd3);
        chk("cont_cnt1", err_count1, 8'd0);

        // 260 erroneous words on channel 0; counter must stick at 255
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 266; i++) begin
            req0_valid = (i < 260);
            req0_code  = 7'h01;
            req1_valid = 1'b0;
            #1;
            if (i == 100) chk("sat_cnt_c100", err_count0, 8'd97);
            if (i == 257) chk("sat_cnt_c257", err_count0, 8'd254);
            if (i == 258) chk("sat_cnt_c258", err_count0, 8'd255);
            if (i == 265) chk("sat_cnt_c265", err_count0, 8'd255);
            tick();
        end
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("clr_valid0", 8'(out0_valid), 8'd1);
        chk("clr_err0", 8'(out0_err), 8'd1);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("clr_cnt0", err_count0, 8'd0);
        tick();
        chk("clr_cnt0_stays", err_count0, 8'd0);

        // Three words accepted back-to-back; reset lands with the third
        req0_valid = 1'b1;
        req0_code  = 7'h01;
        #1;
        chk("mid_ready_a", 8'(req0_ready), 8'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_code  = 7'h40;
        #1;
        chk("mid_ready_b", 8'(req1_ready), 8'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_code  = 7'h55;
        rst        = 1'b1;
        #1;
        chk("mid_ready_c_in_rst", 8'(req0_ready), 8'd1);
        tick();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_code  = 7'h7F;
        req1_valid = 1'b1;
        req1_code  = 7'h00;
        #1;
        chk("mid_next_ready0", 8'(req0_ready), 8'd1);
        chk("mid_next_ready1", 8'(req1_ready), 8'd0);
        chk("mid_out0_err", 8'(out0_err), 8'd0);
        chk("mid_out1_loc", 8'(out1_loc), 8'd0);
        chk("mid_out1_data", 8'(out1_data), 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_no_v0_%0d", i), 8'(out0_valid), 8'd0);
            chk($sformatf("mid_no_v1_%0d", i), 8'(out1_valid), 8'd0);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk("mid_new_valid0", 8'(out0_valid), 8'd1);
        chk("mid_new_data0", 8'(out0_data), 8'hF);
        chk("mid_new_v1", 8'(out1_valid), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
